// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding and MemOp constants for mem_responder.
package mem_resp_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic MEMOP_READ  = 1'b0;
    localparam logic MEMOP_WRITE = 1'b1;
endpackage

// File: rtl/mem_byte_bank.sv
// mem_byte_bank: four byte lanes of WORDS entries, little-endian 32-bit word view.
//   clk   in  rising-edge clock (write port)
//   we    in  write all four lanes of word idx
//   idx   in  word index
//   wdata in  word to write, byte lane b = wdata[8b+7:8b]
//   rdata out word at idx (combinational read)
module mem_byte_bank #(
    parameter int WORDS = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] mem [WORDS];
        always_ff @(posedge clk) begin
            if (we) mem[idx] <= wdata[8*b +: 8];
        end
        assign rdata[8*b +: 8] = mem[idx];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word memory with req/busy/rvalid handshake and fixed access latency.
//   clk, reset  clock and synchronous active-high reset
//   req         request valid, taken only while busy=0
//   MemOp       0 read, 1 write
//   Address     byte address, aligned down to a word
//   wdata       write data, latched at accept
//   busy        high while an access is waiting or responding
//   rvalid      one-cycle response pulse
//   rdata       last read data
//   err         out-of-range flag, valid with rvalid
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int    DEPTH_BYTES = 256,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        MemOp,
    input  logic [31:0] Address,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        op_q, op_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        we;
    logic        in_range;
    logic [31:0] bank_rdata;
    // Full-width compare so high addresses never alias onto the array.
    assign in_range = addr_q < 32'(DEPTH_BYTES);
    mem_byte_bank #(.WORDS(DEPTH_BYTES / 4)) u_bank (
        .clk   (clk),
        .we    (we),
        .idx   (addr_q[AW-1:2]),
        .wdata (wdata_q),
        .rdata (bank_rdata)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        we      = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                state_d = WAIT;
                cnt_d   = 4'(LATENCY - 1);
                addr_d  = Address;
                op_d    = MemOp;
                wdata_d = wdata;
            end
            WAIT: if (cnt_q == 4'd0) begin
                state_d = RESP;
                err_d   = !in_range;
                // Reset on the commit edge must still drop the write.
                we      = op_q == MEMOP_WRITE && in_range && !reset;
                rdata_d = op_q == MEMOP_READ ? (in_range ? bank_rdata : 32'd0) : rdata_q;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            op_q    <= MEMOP_READ;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    assign busy   = state_q != IDLE;
    assign rvalid = state_q == RESP;
    assign rdata  = rdata_q;
    assign err    = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized bench with a cycle-accurate transaction model.
module tb_mem_responder;
    localparam int LAT = 2;
    localparam int DB  = 256;
    logic        clk = 1'b0, reset = 1'b1, req = 1'b0, MemOp = 1'b0;
    logic [31:0] Address = 32'd0, wdata = 32'd0;
    logic        busy, rvalid, err;
    logic [31:0] rdata;
    int          checks = 0, errors = 0;
    mem_responder #(.DEPTH_BYTES(DB), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .req(req), .MemOp(MemOp), .Address(Address),
        .wdata(wdata), .busy(busy), .rvalid(rvalid), .rdata(rdata), .err(err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    // Model: an accept at edge a responds at edge a+LAT and frees the port at a+LAT+2.
    int          cyc = 0, resp_e = 0;
    bit          act = 0, started = 0, e_rv = 0, e_busy = 0, e_err = 0;
    logic [7:0]  mm [DB];
    logic [31:0] la = 0, lw = 0, e_rdata = 0;
    logic        lo = 0;
    always @(posedge clk) begin
        cyc++;
        e_rv = 0;
        if (reset) begin
            act = 0;
            e_rdata = 0;
            started = 1;
        end else if (act && cyc == resp_e) begin
            e_rv = 1;
            if (la < DB) begin
                for (int i = 0; i < 4; i++)
                    if (lo) mm[(la & 32'hFC) + i] = lw[8*i +: 8];
                    else e_rdata[8*i +: 8] = mm[(la & 32'hFC) + i];
            end else if (!lo) e_rdata = 0;
        end else if ((!act || cyc >= resp_e + 2) && req) begin
            act = 1;
            resp_e = cyc + LAT;
            la = Address;
            lo = MemOp;
            lw = wdata;
        end
        e_busy = act && cyc <= resp_e;
        e_err = e_rv && (la >= DB);
    end
    always @(negedge clk) if (started) begin
        chk("busy", 32'(busy), 32'(e_busy));
        chk("rvalid", 32'(rvalid), 32'(e_rv));
        chk("err", 32'(err), 32'(e_err));
        chk("rdata", rdata, e_rdata);
    end
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] d, input bit noise,
                         output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        req = 1; MemOp = op; Address = a; wdata = d;
        @(negedge clk);
        req = 0;
        lat = 0;
        while (!rvalid && lat < 40) begin
            if (noise) begin
                req = 1'($urandom); MemOp = 1'($urandom);
                Address = $urandom_range(0, 300); wdata = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL rvalid_timeout: got none within %0d cycles expected %0d", lat, LAT);
        end
        rd = rdata; er = err;
        req = noise ? 1'($urandom) : 1'b0;
        @(negedge clk);
        req = 0;
    endtask
    task automatic op_reset(input logic op, input logic [31:0] a, input logic [31:0] d, input int k);
        @(negedge clk);
        req = 1; MemOp = op; Address = a; wdata = d;
        @(negedge clk);
        req = 0;
        repeat (k) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
    endtask
    int          lat, t0, r1, r2;
    logic [31:0] rd, d1, d2, prev;
    logic        er;
    initial begin
        reset = 1; req = 1; MemOp = 1; Address = 32'h40; wdata = 32'h1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", 32'(err), 0);
        reset = 0; req = 0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        for (int i = 0; i < DB / 4; i++) do_op(1, 32'(i * 4), $urandom, 0, lat, rd, er);
        do_op(1, 32'h30, 32'h0BADF00D, 0, lat, rd, er);
        do_op(1, 32'h10, 32'hDEADBEEF, 0, lat, rd, er);
        chk("wr_lat", lat, LAT);
        chk("wr_err", 32'(er), 0);
        do_op(0, 32'h10, 32'h0, 0, lat, rd, er);
        chk("rd_lat", lat, LAT);
        chk("rd_data", rd, 32'hDEADBEEF);
        do_op(0, 32'h13, 32'h0, 0, lat, rd, er);
        chk("rd_unaligned", rd, 32'hDEADBEEF);
        do_op(1, 32'h20, 32'h44332211, 0, lat, rd, er);
        chk("byte20", 32'(mm[32'h20]), 32'h11);
        chk("byte23", 32'(mm[32'h23]), 32'h44);
        do_op(0, 32'h20, 32'h0, 0, lat, rd, er);
        chk("rd_byte0", 32'(rd[7:0]), 32'h11);
        chk("rd_word20", rd, 32'h44332211);
        @(negedge clk);
        t0 = cyc; r1 = -1; r2 = -1;
        req = 1; MemOp = 0; Address = 32'h10;
        @(negedge clk);
        Address = 32'h20;
        while (cyc < t0 + 10) begin
            @(negedge clk);
            if (cyc == t0 + 5) req = 0;
            if (rvalid && r1 < 0) begin r1 = cyc; d1 = rdata; end
            else if (rvalid) begin r2 = cyc; d2 = rdata; end
        end
        chk("busy_first_resp", r1 - t0, 3);
        chk("busy_interval", r2 - r1, LAT + 2);
        chk("busy_first_data", d1, 32'hDEADBEEF);
        chk("busy_second_data", d2, 32'h44332211);
        do_op(0, 32'h100, 32'h0, 0, lat, rd, er);
        chk("oob_rd_err", 32'(er), 1);
        chk("oob_rd_data", rd, 0);
        do_op(0, 32'h04, 32'h0, 0, lat, prev, er);
        do_op(1, 32'h104, 32'h12345678, 0, lat, rd, er);
        chk("oob_wr_err", 32'(er), 1);
        do_op(0, 32'h04, 32'h0, 0, lat, rd, er);
        chk("oob_no_wrap", rd, prev);
        op_reset(1, 32'h30, 32'hCAFEF00D, 0);
        do_op(0, 32'h30, 32'h0, 0, lat, rd, er);
        chk("rst_mid_write", rd, 32'h0BADF00D);
        for (int n = 0; n < 250; n++) begin
            logic        op;
            logic [31:0] a;
            op = 1'($urandom);
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DB + 15));
            if ($urandom_range(0, 11) == 0) op_reset(op, a, $urandom, $urandom_range(0, 4));
            else begin
                do_op(op, a, $urandom, 1, lat, rd, er);
                chk("rand_lat", lat, LAT);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
